// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared constants and state encoding for the I2C target.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_ADDR_WIDTH = 7;
    localparam int I2C_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_DATA   = 3'd3,
        RX_ACK    = 3'd4,
        TX_DATA   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_tgt_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_line_sync
//  Description : Synchronizes SCL/SDA into clk and derives SCL edge strobes
//                plus START/STOP detection from the synchronized lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic s_scl,
    output logic s_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    // Synchronizer chains, preset high so reset looks like an idle bus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign s_scl = r_scl_sync[SYNC_STAGES-1];
    assign s_sda = r_sda_sync[SYNC_STAGES-1];

    assign scl_rise = s_scl & ~r_scl_prev;
    assign scl_fall = ~s_scl & r_scl_prev;

    // SCL must be high in both samples, so a simultaneous SCL edge is data
    assign start_det = r_scl_prev & s_scl & r_sda_prev & ~s_sda;
    assign stop_det  = r_scl_prev & s_scl & ~r_sda_prev & s_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target_1byte.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_1byte
//  Description : Single-byte I2C target. Matches a 7-bit address, then either
//                receives one byte (rx_valid) or returns one byte (tx_req).
//                SDA is open-drain: sda_oe=1 pulls the line low.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_1byte
    import i2c_pkg::*;
#(
    parameter int ADDR_WIDTH  = I2C_ADDR_WIDTH,
    parameter int DATA_WIDTH  = I2C_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic [ADDR_WIDTH-1:0] own_addr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_req,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy
);

    localparam int                c_CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    logic w_s_scl;
    logic w_s_sda;
    logic w_scl_rise_raw;
    logic w_scl_fall_raw;
    logic w_start_det;
    logic w_stop_det;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .s_scl     (w_s_scl),
        .s_sda     (w_s_sda),
        .scl_rise  (w_scl_rise_raw),
        .scl_fall  (w_scl_fall_raw),
        .start_det (w_start_det),
        .stop_det  (w_stop_det)
    );

    // Edge strobes qualified by the settled SCL level
    logic w_rise;
    logic w_fall;
    assign w_rise = w_scl_rise_raw & w_s_scl;
    assign w_fall = w_scl_fall_raw & ~w_s_scl;

    i2c_tgt_state_e          r_state, w_state_nx;
    logic [DATA_WIDTH-1:0]   r_sh, w_sh_nx;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_nx;
    logic                    r_phase, w_phase_nx;   // 1 = ACK bit is being driven
    logic                    r_rw, w_rw_nx;
    logic                    r_sda_oe, w_sda_oe_nx;
    logic [DATA_WIDTH-1:0]   r_rx_data, w_rx_data_nx;
    logic                    r_rx_valid, w_rx_valid_nx;
    logic                    r_tx_req, w_tx_req_nx;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   w_shift_in;

    assign w_shift_in = {r_sh[DATA_WIDTH-2:0], w_s_sda};

    // State and datapath registers; reset releases SDA on the sampling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sh       <= w_sh_nx;
            r_cnt      <= w_cnt_nx;
            r_phase    <= w_phase_nx;
            r_rw       <= w_rw_nx;
            r_sda_oe   <= w_sda_oe_nx;
            r_rx_data  <= w_rx_data_nx;
            r_rx_valid <= w_rx_valid_nx;
            r_tx_req   <= w_tx_req_nx;
            r_busy     <= (w_state_nx != IDLE);
        end
    end

    // Next-state and output logic; START/STOP override every state
    always_comb begin
        w_state_nx    = r_state;
        w_sh_nx       = r_sh;
        w_cnt_nx      = r_cnt;
        w_phase_nx    = r_phase;
        w_rw_nx       = r_rw;
        w_sda_oe_nx   = r_sda_oe;
        w_rx_data_nx  = r_rx_data;
        w_rx_valid_nx = 1'b0;
        w_tx_req_nx   = 1'b0;

        if (w_start_det) begin
            w_state_nx  = ADDR;
            w_cnt_nx    = '0;
            w_phase_nx  = 1'b0;
            w_sda_oe_nx = 1'b0;
        end else if (w_stop_det) begin
            w_state_nx  = IDLE;
            w_cnt_nx    = '0;
            w_phase_nx  = 1'b0;
            w_sda_oe_nx = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_sda_oe_nx = 1'b0;
                end
                ADDR: begin
                    if (w_rise) begin
                        w_sh_nx  = w_shift_in;
                        w_cnt_nx = r_cnt + 1'b1;
                        if (r_cnt == c_LAST_BIT) begin
                            if (w_shift_in[ADDR_WIDTH:1] == own_addr) begin
                                w_state_nx  = ADDR_ACK;
                                w_rw_nx     = w_shift_in[0];
                                w_tx_req_nx = w_shift_in[0];
                                w_phase_nx  = 1'b0;
                            end else begin
                                w_state_nx = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nx = 1'b1;
                            w_phase_nx  = 1'b1;
                        end else begin
                            w_phase_nx = 1'b0;
                            w_cnt_nx   = '0;
                            if (r_rw) begin
                                // Byte is latched here, so later tx_data changes are harmless
                                w_sh_nx     = tx_data;
                                w_sda_oe_nx = ~tx_data[DATA_WIDTH-1];
                                w_state_nx  = TX_DATA;
                            end else begin
                                w_sda_oe_nx = 1'b0;
                                w_state_nx  = RX_DATA;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rise) begin
                        w_sh_nx  = w_shift_in;
                        w_cnt_nx = r_cnt + 1'b1;
                        if (r_cnt == c_LAST_BIT) begin
                            w_rx_data_nx  = w_shift_in;
                            w_rx_valid_nx = 1'b1;
                            w_phase_nx    = 1'b0;
                            w_state_nx    = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (w_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nx = 1'b1;
                            w_phase_nx  = 1'b1;
                        end else begin
                            w_sda_oe_nx = 1'b0;
                            w_phase_nx  = 1'b0;
                            w_state_nx  = WAIT_STOP;
                        end
                    end
                end
                TX_DATA: begin
                    // Counter tracks bits already sampled by the controller
                    if (w_rise) begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end else if (w_fall) begin
                        if (r_cnt == '0) begin
                            w_sda_oe_nx = 1'b0;
                            w_state_nx  = TX_ACK;
                        end else begin
                            w_sh_nx     = {r_sh[DATA_WIDTH-2:0], 1'b0};
                            w_sda_oe_nx = ~r_sh[DATA_WIDTH-2];
                        end
                    end
                end
                TX_ACK: begin
                    // Controller ACK/NACK carries no meaning for a single byte
                    if (w_rise) begin
                        w_state_nx = WAIT_STOP;
                    end
                end
                WAIT_STOP: begin
                    w_sda_oe_nx = 1'b0;
                end
                default: begin
                    w_state_nx  = IDLE;
                    w_sda_oe_nx = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_1byte.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_1byte
//  Description : Self-checking bench for i2c_target_1byte. A bit-banged
//                controller drives an open-drain bus; a vector table covers
//                whole transactions, hand sequences cover aborts/Sr/reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_1byte;

    localparam int Q = 5;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_ctrl;
    logic       sda_line;
    logic       sda_oe;
    logic [6:0] own_addr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       busy;

    always #5 clk = ~clk;

    // Open-drain wired-AND of controller and target
    assign sda_line = sda_ctrl & ~sda_oe;

    i2c_target_1byte dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .own_addr (own_addr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int oe_cnt = 0;

    // Pulse/drive counters sampled on the inactive edge
    always @(negedge clk) begin
        if (rx_valid) rx_cnt++;
        if (tx_req)   tx_cnt++;
        if (sda_oe)   oe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_ctrl = 1'b1; wq(Q);
        scl      = 1'b1; wq(Q);
        sda_ctrl = 1'b0; wq(Q);
        scl      = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop;
        sda_ctrl = 1'b0; wq(Q);
        scl      = 1'b1; wq(Q);
        sda_ctrl = 1'b1; wq(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_ctrl = b; wq(Q);
        scl = 1'b1;   wq(2*Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_ctrl = 1'b1; wq(Q);
        scl = 1'b1;      wq(Q);
        b = sda_line;    wq(Q);
        scl = 1'b0;      wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    // Reads a byte; after the MSB the local byte is scrambled to prove it was latched
    task automatic read_byte(input logic [7:0] scramble, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
            if (i == 7) tx_data = scramble;
        end
    endtask

    typedef struct packed {
        logic [6:0] own;
        logic [7:0] addr_byte;
        logic [7:0] wdata;
        logic [7:0] txb;
        logic       exp_aack;    // SDA level on 9th clock of address byte
        logic       exp_dack;    // SDA level on 9th clock of write data
        logic       exp_rx;      // one rx_valid expected
        logic [7:0] exp_rxd;
        logic       exp_tx;      // one tx_req expected
        logic [7:0] exp_rbyte;
        logic       exp_oe;      // target drives SDA at some point
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int idx);
        logic       b;
        logic [7:0] rb;
        int rx0, tx0, oe0;
        own_addr = v.own;
        tx_data  = 8'h00;
        rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cnt;
        i2c_start();
        send_byte(v.addr_byte);
        if (v.addr_byte[0]) tx_data = v.txb;
        check($sformatf("v%0d_busy_mid", idx), busy, 1);
        read_bit(b);
        check($sformatf("v%0d_addr_ack", idx), b, v.exp_aack);
        if (!v.addr_byte[0]) begin
            send_byte(v.wdata);
            read_bit(b);
            check($sformatf("v%0d_data_ack", idx), b, v.exp_dack);
        end else begin
            read_byte(~v.txb, rb);
            check($sformatf("v%0d_read_byte", idx), rb, v.exp_rbyte);
            send_bit(1'b1);
        end
        i2c_stop();
        check($sformatf("v%0d_busy_end", idx), busy, 0);
        check($sformatf("v%0d_rx_pulses", idx), rx_cnt - rx0, {31'd0, v.exp_rx});
        if (v.exp_rx) check($sformatf("v%0d_rx_data", idx), rx_data, v.exp_rxd);
        check($sformatf("v%0d_tx_pulses", idx), tx_cnt - tx0, {31'd0, v.exp_tx});
        check($sformatf("v%0d_oe_used", idx), (oe_cnt - oe0) != 0, v.exp_oe);
    endtask

    initial begin
        logic       b;
        logic [7:0] rb;
        int rx0, tx0;
        vec_t wv;

        //            own    addr   wdata  txb    aack dack rx rxd    tx rbyte  oe
        vecs[0] = '{7'h2A, 8'h54, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{7'h2A, 8'h55, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1};
        vecs[2] = '{7'h2A, 8'h56, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{7'h2A, 8'h57, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{7'h2B, 8'h56, 8'h7E, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{7'h2B, 8'h54, 8'h81, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{7'h2A, 8'h55, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1};

        reset = 1'b1; scl = 1'b1; sda_ctrl = 1'b1; own_addr = 7'h2A; tx_data = 8'h00;
        wq(5);
        reset = 1'b0;
        wq(3);
        check("rst_sda_oe",   sda_oe,   0);
        check("rst_rx_data",  rx_data,  0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req",   tx_req,   0);
        check("rst_busy",     busy,     0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Abort: STOP after four data bits discards the partial byte
        own_addr = 7'h2A;
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'h54);
        read_bit(b);
        check("abort_addr_ack", b, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("abort_busy_before", busy, 1);
        i2c_stop();
        check("abort_busy_after", busy, 0);
        wq(2*Q);
        check("abort_no_rx", rx_cnt - rx0, 0);

        // Repeated START: write 0x11, Sr, then read 0x96
        rx0 = rx_cnt; tx0 = tx_cnt;
        i2c_start();
        send_byte(8'h54);
        read_bit(b);
        check("sr_addr_ack", b, 0);
        send_byte(8'h11);
        read_bit(b);
        check("sr_data_ack", b, 0);
        i2c_start();
        check("sr_rx_pulses", rx_cnt - rx0, 1);
        check("sr_rx_data", rx_data, 8'h11);
        send_byte(8'h55);
        tx_data = 8'h96;
        read_bit(b);
        check("sr_raddr_ack", b, 0);
        check("sr_tx_pulses", tx_cnt - tx0, 1);
        read_byte(8'h69, rb);
        check("sr_read_byte", rb, 8'h96);
        send_bit(1'b1);
        i2c_stop();
        check("sr_busy_end", busy, 0);

        // Reset while the target is driving the address ACK
        i2c_start();
        send_byte(8'h54);
        for (int i = 0; i < 40 && !sda_oe; i++) @(negedge clk);
        check("rst_ack_driven", sda_oe, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_sda_oe",  sda_oe,  0);
        check("rst_mid_rx_data", rx_data, 0);
        check("rst_mid_busy",    busy,    0);
        check("rst_mid_rx_vld",  rx_valid, 0);
        check("rst_mid_tx_req",  tx_req,  0);
        wq(3);
        reset = 1'b0;
        wq(2*Q);
        wv = '{7'h2A, 8'h54, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1};
        run_vec(wv, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
